// File: rtl/nibble_add_arbiter_if.sv
// Request/response bundle between the two client blocks and nibble_add_arbiter.
// The clients drive the master side and the shared adder drives the slave side.
interface nibble_add_arbiter_if #(parameter int WIDTH = 16);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic             cin0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             cin1;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;

    modport master (
        output req_valid, a0, b0, cin0, a1, b1, cin1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, sum, cout, busy
    );

    modport slave (
        input  req_valid, a0, b0, cin0, a1, b1, cin1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, sum, cout, busy
    );
endinterface

// File: rtl/nibble_add_arbiter.sv
// Two-requester wide adder that reuses one 4-bit full-adder slice, rippling
// the latched operands through it one nibble per clock with a registered carry.

module nibble_add_arbiter_fa4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
endmodule

module nibble_add_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nibble_add_arbiter_if.slave  bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NIB - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic [1:0]       grant;
    logic [3:0]       fa_a, fa_b, fa_s;
    logic             fa_co;

    // Round-robin grant: a lone requester always wins, a tie goes to the pointer.
    always_comb begin
        grant = 2'b00;
        if (rst_n && state_q == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    assign fa_a = a_q[{k_q, 2'b00} +: 4];
    assign fa_b = b_q[{k_q, 2'b00} +: 4];

    nibble_add_arbiter_fa4 u_fa4 (
        .a  (fa_a),
        .b  (fa_b),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        id_d    = id_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            IDLE: begin
                if (grant != 2'b00) begin
                    a_d     = grant[1] ? bus.a1   : bus.a0;
                    b_d     = grant[1] ? bus.b1   : bus.b0;
                    carry_d = grant[1] ? bus.cin1 : bus.cin0;
                    id_d    = grant[1];
                    ptr_d   = ~grant[1];
                    k_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                sum_d[{k_q, 2'b00} +: 4] = fa_s;
                carry_d = fa_co;
                if (k_q == K_LAST) begin
                    cout_d  = fa_co;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Status outputs are registered, so they follow the next state.
        rsp_valid_d = (state_d == DONE);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            k_q         <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            id_q        <= 1'b0;
            ptr_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            k_q         <= k_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.req_ready = grant;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.busy      = busy_q;

    a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) grant != 2'b11);
endmodule

// File: tb/tb_nibble_add_arbiter.sv
// Self-checking bench for nibble_add_arbiter: a transaction-level model predicts
// grants, latency and a+b+cin results, checked every cycle, plus directed tests.
module tb_nibble_add_arbiter;
    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    typedef struct {
        logic        id;
        logic [15:0] s;
        logic        c;
        int          lat;
    } resp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cycle = 0;

    nibble_add_arbiter_if #(.WIDTH(WIDTH)) bus ();

    nibble_add_arbiter #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Model state: one outstanding operation at most, counted down to its response.
    bit          m_pending = 0;
    int          m_wait    = 0;
    logic [15:0] m_sum     = '0;
    logic        m_cout    = 1'b0;
    logic        m_id      = 1'b0;
    logic        m_ptr     = 1'b0;
    bit          m_seen    = 0;
    int          m_hs_cycle = 0;
    int          m_vcycle   = 0;
    int          hs_count   = 0;
    int          grant_q[$];
    resp_t       resp_q[$];

    function automatic logic [1:0] rrGrant(input logic [1:0] v, input logic ptr);
        if (v == 2'b01) return 2'b01;
        if (v == 2'b10) return 2'b10;
        if (v == 2'b11) return ptr ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    // Compare process: check outputs mid-cycle, then advance the model across the next edge.
    always @(negedge clk) begin : compare
        logic [1:0]  exp_ready;
        logic [16:0] full;
        resp_t       r;
        if (!rst_n) begin
            checkOutput("rst_req_ready", bus.req_ready, 0);
            checkOutput("rst_rsp_valid", bus.rsp_valid, 0);
            checkOutput("rst_busy", bus.busy, 0);
            checkOutput("rst_rsp_id", bus.rsp_id, 0);
            checkOutput("rst_sum", bus.sum, 0);
            checkOutput("rst_cout", bus.cout, 0);
            m_pending = 0; m_wait = 0; m_sum = '0; m_cout = 1'b0;
            m_id = 1'b0; m_ptr = 1'b0; m_seen = 0;
        end else begin
            exp_ready = m_pending ? 2'b00 : rrGrant(bus.req_valid, m_ptr);
            checkOutput("req_ready", bus.req_ready, exp_ready);
            checkOutput("busy", bus.busy, m_pending);
            checkOutput("rsp_valid", bus.rsp_valid, (m_pending && m_wait == 0));
            checkOutput("rsp_id", bus.rsp_id, m_id);
            if (!(m_pending && m_wait != 0)) begin
                checkOutput("sum", bus.sum, m_sum);
                checkOutput("cout", bus.cout, m_cout);
            end
            if (m_pending && m_wait == 0 && !m_seen) begin
                m_seen   = 1;
                m_vcycle = cycle;
            end
            if (!m_pending) begin
                if (exp_ready != 2'b00) begin
                    if (exp_ready[1])
                        full = 17'(bus.a1) + 17'(bus.b1) + 17'(bus.cin1);
                    else
                        full = 17'(bus.a0) + 17'(bus.b0) + 17'(bus.cin0);
                    {m_cout, m_sum} = full;
                    m_id       = exp_ready[1];
                    m_ptr      = ~exp_ready[1];
                    m_pending  = 1;
                    m_wait     = NIB;
                    m_seen     = 0;
                    m_hs_cycle = cycle;
                    hs_count++;
                    grant_q.push_back(int'(exp_ready[1]));
                end
            end else if (m_wait > 0) begin
                m_wait--;
            end else if (bus.rsp_ready) begin
                r.id  = m_id;
                r.s   = m_sum;
                r.c   = m_cout;
                r.lat = m_vcycle - m_hs_cycle;
                resp_q.push_back(r);
                m_pending = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [15:0] a0v, input logic [15:0] b0v, input logic c0v,
                                 input logic [15:0] a1v, input logic [15:0] b1v, input logic c1v,
                                 input logic rr);
        bus.req_valid = v;
        bus.a0 = a0v; bus.b0 = b0v; bus.cin0 = c0v;
        bus.a1 = a1v; bus.b1 = b1v; bus.cin1 = c1v;
        bus.rsp_ready = rr;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n = 0;
        while (m_pending && n < 200) begin
            stepCycle();
            n++;
        end
        if (m_pending) checkOutput("wait_idle_timeout", 1, 0);
    endtask

    task automatic doOp(input logic id, input logic [15:0] a, input logic [15:0] b, input logic c);
        int hs0, rc0, n;
        waitIdle();
        hs0 = hs_count;
        rc0 = resp_q.size();
        if (id) begin
            bus.a1 = a; bus.b1 = b; bus.cin1 = c; bus.req_valid = 2'b10;
        end else begin
            bus.a0 = a; bus.b0 = b; bus.cin0 = c; bus.req_valid = 2'b01;
        end
        n = 0;
        while (hs_count == hs0 && n < 20) begin
            stepCycle();
            n++;
        end
        bus.req_valid = 2'b00;
        if (hs_count == hs0) checkOutput("handshake_timeout", 1, 0);
        n = 0;
        while (resp_q.size() == rc0 && n < 100) begin
            stepCycle();
            n++;
        end
        if (resp_q.size() == rc0) checkOutput("response_timeout", 1, 0);
    endtask

    function automatic resp_t lastResp();
        resp_t r;
        r.id = 1'b0; r.s = 16'hxxxx; r.c = 1'bx; r.lat = -1;
        if (resp_q.size() > 0) r = resp_q[resp_q.size()-1];
        return r;
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resp_t r;
        int    hs0, rc0, g0, n, stable, both;

        applyStimulus(2'b00, 16'h0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset_req_ready", bus.req_ready, 0);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 0);
        checkOutput("reset_busy", bus.busy, 0);
        checkOutput("reset_sum", bus.sum, 0);
        checkOutput("reset_cout", bus.cout, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        stepCycle();

        $display("[TB] basic add");
        doOp(1'b0, 16'h1234, 16'h4321, 1'b0);
        r = lastResp();
        checkOutput("basic_sum", r.s, 16'h5555);
        checkOutput("basic_cout", r.c, 0);
        checkOutput("basic_id", r.id, 0);
        checkOutput("basic_latency", r.lat, 5);

        $display("[TB] full carry ripple");
        doOp(1'b1, 16'hFFFF, 16'h0001, 1'b0);
        r = lastResp();
        checkOutput("ripple_sum", r.s, 16'h0000);
        checkOutput("ripple_cout", r.c, 1);
        checkOutput("ripple_id", r.id, 1);
        doOp(1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
        r = lastResp();
        checkOutput("allones_sum", r.s, 16'hFFFF);
        checkOutput("allones_cout", r.c, 1);

        $display("[TB] round robin");
        waitIdle();
        g0 = grant_q.size();
        rc0 = resp_q.size();
        both = 0;
        applyStimulus(2'b11, 16'h1111, 16'h2222, 1'b0, 16'h3333, 16'h4444, 1'b1, 1'b1);
        n = 0;
        while (grant_q.size() < g0 + 4 && n < 100) begin
            stepCycle();
            if (bus.req_ready === 2'b11) both++;
            n++;
        end
        bus.req_valid = 2'b00;
        waitIdle();
        checkOutput("rr_never_both", both, 0);
        checkOutput("rr_grant_count", grant_q.size() - g0, 4);
        checkOutput("rr_response_count", resp_q.size() - rc0, 4);
        for (int i = 0; i < 4; i++) begin
            if (grant_q.size() > g0 + i) checkOutput($sformatf("rr_grant%0d", i), grant_q[g0 + i], i % 2);
            if (resp_q.size() > rc0 + i)
                checkOutput($sformatf("rr_sum%0d", i), resp_q[rc0 + i].s, (i % 2) ? 16'h7778 : 16'h3333);
        end

        $display("[TB] back-pressure");
        hs0 = hs_count;
        bus.rsp_ready = 1'b0;
        bus.a0 = 16'hABCD; bus.b0 = 16'h1111; bus.cin0 = 1'b1; bus.req_valid = 2'b01;
        stepCycle();
        bus.req_valid = 2'b00;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            stepCycle();
            n++;
        end
        checkOutput("bp_latency_after_first_calc", n, 4);
        bus.req_valid = 2'b11;
        stable = 0;
        repeat (10) begin
            stepCycle();
            if (bus.rsp_valid === 1'b1 && bus.busy === 1'b1 && bus.req_ready === 2'b00 &&
                bus.sum === 16'hBCDF && bus.cout === 1'b0 && bus.rsp_id === 1'b0) stable++;
        end
        bus.req_valid = 2'b00;
        checkOutput("bp_stable_cycles", stable, 10);
        checkOutput("bp_single_grant", hs_count - hs0, 1);
        bus.rsp_ready = 1'b1;
        stepCycle();
        checkOutput("bp_release_busy", bus.busy, 0);
        checkOutput("bp_release_valid", bus.rsp_valid, 0);

        $display("[TB] reset mid-operation");
        rc0 = resp_q.size();
        bus.a0 = 16'h5A5A; bus.b0 = 16'h0F0F; bus.cin0 = 1'b0; bus.req_valid = 2'b01;
        stepCycle();
        bus.req_valid = 2'b00;
        stepCycle();
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_busy", bus.busy, 0);
        checkOutput("midrst_rsp_valid", bus.rsp_valid, 0);
        checkOutput("midrst_sum", bus.sum, 0);
        checkOutput("midrst_cout", bus.cout, 0);
        checkOutput("midrst_req_ready", bus.req_ready, 0);
        repeat (2) stepCycle();
        rst_n = 1'b1;
        repeat (8) stepCycle();
        checkOutput("midrst_no_response", resp_q.size() - rc0, 0);
        doOp(1'b0, 16'h00F0, 16'h0F10, 1'b0);
        r = lastResp();
        checkOutput("post_rst_sum", r.s, 16'h1000);
        checkOutput("post_rst_cout", r.c, 0);
        checkOutput("post_rst_id", r.id, 0);

        $display("[TB] random sweep");
        hs0 = hs_count;
        rc0 = resp_q.size();
        n = 0;
        while (hs_count < hs0 + 1000 && n < 40000) begin
            applyStimulus(2'($urandom_range(0, 3)),
                          16'($urandom), 16'($urandom), 1'($urandom),
                          16'($urandom), 16'($urandom), 1'($urandom),
                          ($urandom_range(0, 3) != 0));
            stepCycle();
            n++;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        waitIdle();
        checkOutput("rand_handshakes", hs_count - hs0, 1000);
        checkOutput("rand_responses", resp_q.size() - rc0, 1000);

        repeat (2) stepCycle();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
